// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory arbiter: grant encoding, access
// direction constants and default bus widths.
package mips_mem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_PIPE = 2'd1;
  localparam gnt_t GNT_LDR  = 2'd2;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundles the pipeline, loader and memory sides of the data-memory arbiter.
// slave = arbiter view, master = surrounding logic / memory view.
interface data_mem_arbiter_if #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int SCW = 8
);
  logic          pipe_en;
  logic          pipe_rw;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;

  logic          ldr_req;
  logic          ldr_rw;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_lock;
  logic          ldr_gnt;
  logic          ldr_rvalid;
  logic [DW-1:0] ldr_rdata;

  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [SCW-1:0] stall_cnt;

  modport slave (
    input  pipe_en, pipe_rw, pipe_addr, pipe_wdata,
    input  ldr_req, ldr_rw, ldr_addr, ldr_wdata, ldr_lock,
    input  mem_rdata,
    output pipe_stall, ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_rw, mem_addr, mem_wdata, stall_cnt
  );

  modport master (
    output pipe_en, pipe_rw, pipe_addr, pipe_wdata,
    output ldr_req, ldr_rw, ldr_addr, ldr_wdata, ldr_lock,
    output mem_rdata,
    input  pipe_stall, ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_rw, mem_addr, mem_wdata, stall_cnt
  );
endinterface

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int           W     = 2,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk4,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && cnt != LIMIT)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has priority, loader
// gets a forced slot after MAX_WAIT consecutive losses or owns it under lock.
module data_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 3,
  parameter int WCW      = 2,
  parameter int SCW      = 8
) (
  input logic             clk4,
  input logic             rst_n,
  data_mem_arbiter_if.slave bus
);

  gnt_t           gnt;
  logic [WCW-1:0] wait_cnt;
  logic           force_ldr;
  logic           rvalid_q;

  assign force_ldr = bus.ldr_req && (wait_cnt == WCW'(MAX_WAIT));

  always_comb begin
    gnt = GNT_NONE;
    if (bus.ldr_req && (bus.ldr_lock || force_ldr || !bus.pipe_en))
      gnt = GNT_LDR;
    else if (bus.pipe_en && !bus.ldr_lock)
      gnt = GNT_PIPE;
  end

  // Idle cycles still drive the pipeline address/data so nothing floats.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_rw    = MEM_RD;
    bus.mem_addr  = bus.pipe_addr;
    bus.mem_wdata = bus.pipe_wdata;
    case (gnt)
      GNT_PIPE: begin
        bus.mem_en = 1'b1;
        bus.mem_rw = bus.pipe_rw;
      end
      GNT_LDR: begin
        bus.mem_en    = 1'b1;
        bus.mem_rw    = bus.ldr_rw;
        bus.mem_addr  = bus.ldr_addr;
        bus.mem_wdata = bus.ldr_wdata;
      end
      default: ;
    endcase
  end

  assign bus.ldr_gnt    = (gnt == GNT_LDR);
  assign bus.pipe_stall = bus.pipe_en && (gnt != GNT_PIPE);

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) rvalid_q <= 1'b0;
    else        rvalid_q <= (gnt == GNT_LDR) && (bus.ldr_rw == MEM_RD);
  end

  assign bus.ldr_rvalid = rvalid_q;
  assign bus.ldr_rdata  = bus.mem_rdata;

  // Counts consecutive loader losses; any grant or withdrawn request restarts it.
  sat_counter #(.W(WCW), .LIMIT(WCW'(MAX_WAIT))) u_wait_cnt (
    .clk4  (clk4),
    .rst_n (rst_n),
    .clr   (!bus.ldr_req || bus.ldr_gnt),
    .inc   (1'b1),
    .cnt   (wait_cnt)
  );

  sat_counter #(.W(SCW), .LIMIT({SCW{1'b1}})) u_stall_cnt (
    .clk4  (clk4),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (bus.pipe_stall),
    .cnt   (bus.stall_cnt)
  );

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data memory between the pipeline MEM stage and a loader/debug port.
- The loader port is used for program/data preload and inspection over the board interface.
- Sits between the EX/MEM pipeline register outputs and the data memory array; drives the memory enable, read/write, address and write data.
- The pipeline has priority; a starvation counter forces a loader slot after MAX_WAIT losses and stalls the pipeline for that cycle.

Parameters:
- AW, 8, address width (matches the ALU result width used as address)
- DW, 8, data width
- MAX_WAIT, 3, consecutive loader losses before a loader grant is forced (1..2^WCW-1)
- WCW, 2, wait counter width
- SCW, 8, stall statistics counter width

Ports:
- clk4  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_en  in  1  pipeline memory access request (MEM stage)
- pipe_rw  in  1  1 = write, 0 = read
- pipe_addr  in  AW  pipeline address
- pipe_wdata  in  DW  pipeline store data (bypassed B)
- pipe_stall  out  1  pipeline must hold MEM stage this cycle
- ldr_req  in  1  loader request; held with addr/rw/wdata stable until ldr_gnt
- ldr_rw  in  1  1 = write, 0 = read
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_lock  in  1  exclusive loader mode; pipeline is always denied
- ldr_gnt  out  1  request consumed at this rising edge
- ldr_rvalid  out  1  loader read data valid (one cycle after a read grant)
- ldr_rdata  out  DW  loader read data
- mem_en  out  1  memory enable
- mem_rw  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory synchronous read data, valid the cycle after a read enable
- stall_cnt  out  SCW  saturating count of pipe_stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - wait_cnt=0, ldr_rvalid=0, stall_cnt=0.
  - Combinational outputs follow the grant rule with the counter at 0.
  - Reset mid-read drops the pending rvalid; no late pulse after release.
- Grant rule, evaluated combinationally each cycle:
  - force = ldr_req & (wait_cnt==MAX_WAIT).
  - LDR when ldr_req & (ldr_lock | force | ~pipe_en).
  - Otherwise PIPE when pipe_en & ~ldr_lock.
  - Otherwise NONE.
- Memory mux:
  - PIPE: mem_* = pipe_*, mem_en=1.
  - LDR: mem_* = ldr_*, mem_en=1.
  - NONE: mem_en=0, mem_rw=0, addr/wdata = pipe_* (don't-care but defined).
- ldr_gnt=1 iff grant==LDR.
- pipe_stall=1 iff pipe_en & grant!=PIPE.
- Pipeline read data is taken by the pipeline directly from mem_rdata; the arbiter does not register it.
- wait_cnt, registered:
  - Cleared if ~ldr_req or ldr_gnt.
  - Else incremented, saturating at MAX_WAIT.
  - Consequence: at most MAX_WAIT consecutive losses, then exactly one forced grant, then the pipeline wins again.
- ldr_rvalid, registered: set to (grant==LDR & ~ldr_rw), a one-cycle pulse. ldr_rdata = mem_rdata (qualified by ldr_rvalid).
- Back-to-back loader requests:
  - Allowed; a new request may be presented the cycle after ldr_gnt.
  - The rvalid of request N coincides with the grant cycle of request N+1.
- stall_cnt increments on every pipe_stall cycle and saturates at all-ones; it never wraps.
- Simultaneous requests: pipe wins unless force or ldr_lock.
- ldr_lock with no ldr_req: the pipeline is still stalled and the memory is idle.
- Write-then-read to the same address on consecutive cycles returns the new data (memory write-first); the arbiter adds no hazard logic.

Decomposition:
- Shared package mips_mem_pkg holds:
  - Grant encoding constants: GNT_NONE=2'd0, GNT_PIPE=2'd1, GNT_LDR=2'd2.
  - MEM_RD=1'b0, MEM_WR=1'b1.
  - AW/DW defaults.
- One natural sub-module: sat_counter (parameterised width and limit, clear/inc). Instantiated twice: wait_cnt with limit MAX_WAIT, stall_cnt with limit all-ones.

Test Plan:
- Reset release with all requests low -> mem_en=0, pipe_stall=0, ldr_gnt=0, ldr_rvalid=0, stall_cnt=0.
- Pipe write addr 8'h05 data 8'h0a, then pipe read addr 8'h05 -> mem_en=1 with mem_rw=1 then 0; next cycle mem_rdata=8'h0a; pipe_stall=0 throughout.
- Loader write addr 8'h10 data 8'h14 with pipe idle, then loader read 8'h10 -> ldr_gnt in the same cycle each time; ldr_rvalid one cycle after the read grant with ldr_rdata=8'h14.
- pipe_en held high and ldr_req held for 10 cycles, MAX_WAIT=3 -> loader granted on cycles 4 and 8; pipe_stall exactly on those cycles; stall_cnt=2.
- ldr_lock=1 with pipe_en=1 and back-to-back loader reads -> ldr_gnt every cycle, pipe_stall constant; stall_cnt saturates at 8'hff after 255+ cycles with no wrap.
- rst_n asserted the cycle after a loader read grant -> ldr_rvalid stays 0; wait_cnt and stall_cnt read 0 after release.
